// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a FIFO: pops a word whenever one is available and
// sends it as start bit, DATA_WIDTH data bits LSB first, stop bit, back to back.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done_tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  tx_q, tx_d;
  logic                  cnt_last_s;

  assign cnt_last_s = (cnt_q == CNT_LAST);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      bit_q   <= {BW{1'b0}};
      shreg_q <= {DATA_WIDTH{1'b0}};
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        if (fifo_rd) begin
          shreg_d = fifo_r_data;
          cnt_d   = {CW{1'b0}};
          bit_d   = {BW{1'b0}};
          state_d = START;
          tx_d    = 1'b0;
        end else begin
          tx_d = 1'b1;
        end
      end
      START: begin
        if (cnt_last_s) begin
          cnt_d   = {CW{1'b0}};
          state_d = DATA;
          tx_d    = shreg_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_last_s) begin
          cnt_d = {CW{1'b0}};
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + BW'(1);
            shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
            // Drive the bit that lands in position 0 after this shift.
            tx_d    = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_last_s) begin
          cnt_d = {CW{1'b0}};
          if (fifo_rd) begin
            shreg_d = fifo_r_data;
            bit_d   = {BW{1'b0}};
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Outputs: pop only when idle or in the final stop cycle, never during reset.
  always_comb begin
    fifo_rd      = 1'b0;
    tx_done_tick = 1'b0;
    case (state_q)
      IDLE: begin
        fifo_rd = ~reset & ~fifo_empty;
      end
      STOP: begin
        fifo_rd      = ~reset & ~fifo_empty & cnt_last_s;
        tx_done_tick = cnt_last_s;
      end
      default: begin
        fifo_rd      = 1'b0;
        tx_done_tick = 1'b0;
      end
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);

endmodule
